// File: rtl/prog_counter_if.sv
// Control/status bundle for prog_counter: the master drives controls, the slave (counter) drives status.
interface prog_counter_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              clr;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              en;
    logic              up;
    logic [STEP_W-1:0] step;
    logic              ovf_clr;
    logic [WIDTH-1:0]  count;
    logic              tc;
    logic              wrap_evt;
    logic              ovf_sticky;

    modport master (
        output clr, load, load_val, en, up, step, ovf_clr,
        input  count, tc, wrap_evt, ovf_sticky
    );

    modport slave (
        input  clr, load, load_val, en, up, step, ovf_clr,
        output count, tc, wrap_evt, ovf_sticky
    );
endinterface

// File: rtl/prog_counter.sv
// Modulo-(MOD_MAX+1) up/down counter with programmable step, wrap or saturate
// at the boundaries, a one-cycle boundary pulse and a sticky boundary flag.
module prog_counter #(
    parameter int WIDTH    = 8,
    parameter int MOD_MAX  = 255,
    parameter int STEP_W   = 4,
    parameter int SATURATE = 0
) (
    input  logic          clk,
    input  logic          rst,
    prog_counter_if.slave bus
);
    // One bit wider than the widest operand so count+step never truncates.
    localparam int AW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;
    localparam logic [AW-1:0]    MAX_A  = AW'(MOD_MAX);
    localparam logic [AW-1:0]    SPAN_A = AW'(MOD_MAX + 1);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MOD_MAX);

    logic [WIDTH-1:0] count_reg, count_next;
    logic             wrap_reg, wrap_next;
    logic             sticky_reg, sticky_next;

    logic [AW-1:0] cnt_a, step_a, s_a, sum_a, load_a;
    logic          evt;

    always_comb begin
        cnt_a  = AW'(count_reg);
        step_a = AW'(bus.step);
        s_a    = (step_a > MAX_A) ? MAX_A : step_a;
        sum_a  = cnt_a + s_a;
        load_a = AW'(bus.load_val);

        count_next = count_reg;
        evt        = 1'b0;

        if (bus.clr) begin
            count_next = '0;
        end else if (bus.load) begin
            count_next = (load_a > MAX_A) ? MAX_W : bus.load_val;
        end else if (bus.en && (s_a != '0)) begin
            // A saturated counter already at its limit also lands in the
            // overflow branch because s>0, so it raises an event too.
            if (bus.up) begin
                if (sum_a > MAX_A) begin
                    evt        = 1'b1;
                    count_next = (SATURATE != 0) ? MAX_W : WIDTH'(sum_a - SPAN_A);
                end else begin
                    count_next = WIDTH'(sum_a);
                end
            end else begin
                if (s_a > cnt_a) begin
                    evt        = 1'b1;
                    count_next = (SATURATE != 0) ? '0 : WIDTH'(cnt_a + SPAN_A - s_a);
                end else begin
                    count_next = WIDTH'(cnt_a - s_a);
                end
            end
        end

        wrap_next   = evt;
        // Set wins over a simultaneous clear.
        sticky_next = evt | (sticky_reg & ~bus.ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg  <= '0;
            wrap_reg   <= 1'b0;
            sticky_reg <= 1'b0;
        end else begin
            count_reg  <= count_next;
            wrap_reg   <= wrap_next;
            sticky_reg <= sticky_next;
        end
    end

    assign bus.count      = count_reg;
    assign bus.wrap_evt   = wrap_reg;
    assign bus.ovf_sticky = sticky_reg;
    assign bus.tc         = bus.en & ((bus.up & (count_reg == MAX_W)) |
                                      (~bus.up & (count_reg == '0)));
endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: a wrap-mode and a saturate-mode instance,
// both WIDTH=8, MOD_MAX=9, STEP_W=4, checked with immediate assertions.
module tb_prog_counter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    prog_counter_if #(.WIDTH(8), .STEP_W(4)) bw ();
    prog_counter_if #(.WIDTH(8), .STEP_W(4)) bs ();

    prog_counter #(.WIDTH(8), .MOD_MAX(9), .STEP_W(4), .SATURATE(0)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bw.slave)
    );

    prog_counter #(.WIDTH(8), .MOD_MAX(9), .STEP_W(4), .SATURATE(1)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bs.slave)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d wrap: count=%0d evt=%0d sticky=%0d | sat: count=%0d evt=%0d sticky=%0d",
                 cyc, bw.count, bw.wrap_evt, bw.ovf_sticky, bs.count, bs.wrap_evt, bs.ovf_sticky);
    endtask

    task automatic check_w(input string tag, input int c, input int w, input int s);
        check({tag, ".count"},  int'(bw.count),      c);
        check({tag, ".wrap"},   int'(bw.wrap_evt),   w);
        check({tag, ".sticky"}, int'(bw.ovf_sticky), s);
    endtask

    task automatic check_s(input string tag, input int c, input int w, input int s);
        check({tag, ".count"},  int'(bs.count),      c);
        check({tag, ".wrap"},   int'(bs.wrap_evt),   w);
        check({tag, ".sticky"}, int'(bs.ovf_sticky), s);
    endtask

    initial begin
        int exp_cnt [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

        rst = 1'b1;
        bw.clr = 0; bw.load = 0; bw.load_val = '0; bw.en = 0; bw.up = 0; bw.step = '0; bw.ovf_clr = 0;
        bs.clr = 0; bs.load = 0; bs.load_val = '0; bs.en = 0; bs.up = 0; bs.step = '0; bs.ovf_clr = 0;
        tick();
        tick();
        check_w("reset_w", 0, 0, 0);
        check_s("reset_s", 0, 0, 0);

        // Up count by 1 from reset, wrapping after 9.
        rst = 1'b0;
        bw.en = 1; bw.up = 1; bw.step = 4'd1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_w($sformatf("upcount[%0d]", i), exp_cnt[i],
                    (exp_cnt[i] == 0) ? 1 : 0, (i >= 9) ? 1 : 0);
            if (exp_cnt[i] == 9) check("tc_at_max", int'(bw.tc), 1);
        end

        // Load 2, then step down by 3 across zero.
        bw.en = 0; bw.load = 1; bw.load_val = 8'd2;
        tick();
        check_w("load2", 2, 0, 1);
        bw.load = 0; bw.en = 1; bw.up = 0; bw.step = 4'd3;
        #1;
        check("tc_down_at2", int'(bw.tc), 0);
        tick();
        check_w("down_wrap", 9, 1, 1);

        // ovf_clr on the same edge as a wrap: set wins; then clear alone.
        bw.up = 1; bw.step = 4'd1; bw.ovf_clr = 1;
        tick();
        check_w("clr_vs_evt", 0, 1, 1);
        bw.en = 0;
        tick();
        check_w("ovf_clr", 0, 0, 0);
        bw.ovf_clr = 0;

        // Load clamps to MOD_MAX; clr beats load.
        bw.load = 1; bw.load_val = 8'd200;
        tick();
        check_w("load200", 9, 0, 0);
        bw.clr = 1;
        tick();
        check_w("clr_load", 0, 0, 0);
        bw.clr = 0; bw.load = 0;

        // Zero step holds without an event.
        bw.en = 1; bw.up = 1; bw.step = 4'd0;
        tick();
        check_w("step0", 0, 0, 0);

        // Step 15 is clamped to 9: 3 + 9 = 12 -> 2 with a wrap.
        bw.en = 0; bw.load = 1; bw.load_val = 8'd3;
        tick();
        bw.load = 0; bw.en = 1; bw.step = 4'd15;
        tick();
        check_w("step_clamp", 2, 1, 1);

        // Reset at count 5 overrides load, en and ovf_clr.
        bw.en = 0; bw.load = 1; bw.load_val = 8'd5;
        tick();
        check_w("load5", 5, 0, 1);
        rst = 1; bw.load_val = 8'd7; bw.en = 1; bw.ovf_clr = 1; bw.step = 4'd1;
        tick();
        check_w("rst_mid", 0, 0, 0);
        rst = 0; bw.load = 0; bw.ovf_clr = 0;
        tick();
        check_w("resume", 1, 0, 0);
        bw.en = 0;

        // Saturate mode: 7 + 5 pins at 9, and again at 9.
        bs.load = 1; bs.load_val = 8'd7;
        tick();
        check_s("sat_load7", 7, 0, 0);
        bs.load = 0; bs.en = 1; bs.up = 1; bs.step = 4'd5;
        tick();
        check_s("sat_up1", 9, 1, 1);
        check("sat_tc", int'(bs.tc), 1);
        tick();
        check_s("sat_up2", 9, 1, 1);

        // Saturate downward: 9-3=6 with no event, then 1-3 pins at 0.
        bs.up = 0; bs.step = 4'd3; bs.ovf_clr = 1;
        tick();
        check_s("sat_dn", 6, 0, 0);
        bs.ovf_clr = 0; bs.en = 0; bs.load = 1; bs.load_val = 8'd1;
        tick();
        bs.load = 0; bs.en = 1;
        tick();
        check_s("sat_dn0", 0, 1, 1);
        tick();
        check_s("sat_dn0b", 0, 1, 1);
        bs.en = 0;
        tick();
        check_s("sat_idle", 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter WIDTH, default 8, count register width in bits.
REQ-002 Parameter MOD_MAX, default 255, highest legal count value; 1 <= MOD_MAX <= 2^WIDTH-1.
REQ-003 Parameter STEP_W, default 4, width of the step input.
REQ-004 Parameter SATURATE, default 0; 0 = wrap mode, 1 = saturate mode.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 clr  input  1  synchronous clear of count.
REQ-008 load  input  1  synchronous load of load_val.
REQ-009 load_val  input  WIDTH  value to load.
REQ-010 en  input  1  count enable.
REQ-011 up  input  1  direction: 1 = up, 0 = down.
REQ-012 step  input  STEP_W  increment or decrement amount per enabled cycle.
REQ-013 ovf_clr  input  1  clears ovf_sticky.
REQ-014 count  output  WIDTH  registered count value, always in 0..MOD_MAX.
REQ-015 tc  output  1  terminal-count flag, combinational.
REQ-016 wrap_evt  output  1  registered single-cycle boundary-event pulse.
REQ-017 ovf_sticky  output  1  registered sticky boundary-event flag.

Function
REQ-018 Per-edge priority SHALL be: rst, then clr, then load, then en, then hold.
REQ-019 On clr: count SHALL become 0; wrap_evt SHALL be 0; ovf_sticky SHALL be unaffected by clr (ovf_clr still applies).
REQ-020 On load: count SHALL become min(load_val, MOD_MAX), independent of en; wrap_evt SHALL be 0.
REQ-021 The effective step s SHALL be min(step, MOD_MAX); s = 0 SHALL hold count with no event.
REQ-022 en=1, up=1, count+s <= MOD_MAX: count SHALL become count+s.
REQ-023 en=1, up=1, count+s > MOD_MAX: wrap mode SHALL give count+s-(MOD_MAX+1); saturate mode SHALL give MOD_MAX.
REQ-024 en=1, up=0, s <= count: count SHALL become count-s.
REQ-025 en=1, up=0, s > count: wrap mode SHALL give count+(MOD_MAX+1)-s; saturate mode SHALL give 0.
REQ-026 Intermediate arithmetic SHALL be at least WIDTH+1 bits wide, so no intermediate truncation occurs (MOD_MAX = 2^WIDTH-1 included).
REQ-027 A boundary event SHALL be either the REQ-023 or REQ-025 condition.
REQ-028 In saturate mode, an enabled s>0 step attempted while count is already at MOD_MAX (up) or 0 (down) SHALL also be a boundary event.
REQ-029 wrap_evt SHALL be 1 for exactly the cycle following the edge whose update was a boundary event, aligned with the new count; otherwise it SHALL be 0.
REQ-030 ovf_sticky SHALL set on any boundary event and clear on ovf_clr; if both occur on the same edge, the set SHALL win.
REQ-031 tc SHALL be en & ((up & count==MOD_MAX) | (~up & count==0)).
REQ-032 Latency: count, wrap_evt and ovf_sticky SHALL reflect an input exactly one clock edge after it is sampled.

Reset
REQ-033 On rst: count, wrap_evt and ovf_sticky SHALL all be 0 on the next edge, overriding clr, load, en and ovf_clr.
REQ-034 rst asserted mid-count SHALL take effect on that edge with no residual event pulse.
REQ-035 Counting SHALL resume from 0 on the first edge with rst=0.

Verification (WIDTH=8, MOD_MAX=9, STEP_W=4 unless stated)
REQ-036 Wrap mode, en=1, up=1, step=1 from reset, 12 cycles -> count 1..9, 0, 1, 2; wrap_evt high only with count=0; ovf_sticky=1 from then on.
REQ-037 Wrap mode, load_val=2, then up=0, step=3 -> count 9; wrap_evt pulses; tc=0 at count 2 (up=0, count!=0).
REQ-038 SATURATE=1, load_val=7, up=1, step=5, two cycles -> count 9, 9; wrap_evt high on both cycles.
REQ-039 load_val=200 -> count=9; clr and load asserted together -> count=0.
REQ-040 ovf_clr asserted on the same edge as a wrap event -> ovf_sticky stays 1; ovf_clr the next cycle with no event -> ovf_sticky=0.
REQ-041 rst asserted at count=5 together with load, en and ovf_clr -> count=0, wrap_evt=0, ovf_sticky=0 on the next cycle.
